// File: rtl/cla_pkg.sv
// Shared types for the 64-bit carry-lookahead adder datapath.
package cla_pkg;
  localparam int CLA_WIDTH = 64;

  typedef struct packed {
    logic                 cout;
    logic [CLA_WIDTH-1:0] sum;
  } cla_result_t;
endpackage

// File: rtl/cla_fifo_ctrl.sv
// FIFO bookkeeping: pointers, occupancy, full/empty and handshake qualification.
module cla_fifo_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          sum_valid,
  input  logic          out_ready,
  output logic          wr,
  output logic          rd,
  output logic          drop,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // A read frees a slot, so a full buffer can still accept a write that cycle.
  // Everything is gated by reset so the reset cycle ignores inputs entirely.
  always_comb begin
    rd   = 1'b0;
    wr   = 1'b0;
    drop = 1'b0;
    if (!reset) begin
      rd   = out_ready & ~empty;
      wr   = sum_valid & (~full | rd);
      drop = sum_valid & ~wr;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/cla_result_buffer.sv
// Registered result stage after the CLA: show-ahead FIFO of {cout, sum} plus
// saturating carry-out and drop statistics.
module cla_result_buffer
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         sum_in,
  input  logic                     cout_in,
  input  logic                     sum_valid,
  output logic [WIDTH:0]           out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         carry_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);
  localparam int AW = $clog2(DEPTH);

  logic          wr, rd, drop, empty;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [WIDTH:0] mem [DEPTH];

  cla_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW)) u_ctrl (
    .clock     (clock),
    .reset     (reset),
    .sum_valid (sum_valid),
    .out_ready (out_ready),
    .wr        (wr),
    .rd        (rd),
    .drop      (drop),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Storage needs no reset: out_valid masks stale entries.
  always_ff @(posedge clock) begin
    if (wr) mem[wr_ptr] <= {cout_in, sum_in};
  end

  // Show-ahead head entry; stays put until it is read.
  assign out_data  = mem[rd_ptr];
  assign out_valid = ~empty;

  // Saturating statistics; only accepted writes count carries, only rejected ones count drops.
  always_ff @(posedge clock) begin
    if (reset) begin
      carry_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (wr && cout_in && carry_cnt != '1) carry_cnt <= carry_cnt + 1'b1;
      if (drop && drop_cnt != '1)           drop_cnt  <= drop_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_cla_result_buffer.sv
// Directed bench for cla_result_buffer with hand-computed expected values.
module tb_cla_result_buffer;
  import cla_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] sum_in;
  logic        cout_in;
  logic        sum_valid;
  logic [64:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        full;
  logic [3:0]  count;
  logic [15:0] carry_cnt;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  cla_result_buffer #(.WIDTH(64), .DEPTH(8), .CNT_W(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .sum_in    (sum_in),
    .cout_in   (cout_in),
    .sum_valid (sum_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .full      (full),
    .count     (count),
    .carry_cnt (carry_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; sampling happens 1ns later, away from the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Present an adder result computed from operands a+b for one cycle.
  task automatic push(input logic [63:0] a, input logic [63:0] b, input logic rdy);
    cla_result_t r;
    r = a + b;
    sum_in    = r.sum;
    cout_in   = r.cout;
    sum_valid = 1'b1;
    out_ready = rdy;
    tick();
    sum_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sum_in = '0; cout_in = 1'b0; sum_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_carry", carry_cnt, 0);
    chk("rst_drop", drop_cnt, 0);

    // 1: single result with carry, one-cycle latency
    push(64'h00FF_00FF_00FF_00FF, 64'hFF00_FF00_FF00_FF01, 1'b0);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, {1'b1, 64'h0});
    chk("t1_carry", carry_cnt, 1);

    // 2: two results, head stable until read
    do_reset();
    push(64'h8080_8080_8080_80FF, 64'h8080_8080_8080_8001, 1'b0);
    push(64'h0888_8888_8888_8888, 64'h0888_8888_8888_8888, 1'b0);
    chk("t2_count", count, 2);
    chk("t2_head0", out_data, {1'b1, 64'h0101_0101_0101_0100});
    tick();
    chk("t2_hold", out_data, {1'b1, 64'h0101_0101_0101_0100});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t2_head1", out_data, {1'b0, 64'h1111_1111_1111_1110});
    chk("t2_count1", count, 1);

    // 3: fill and overflow
    do_reset();
    for (int i = 0; i < 10; i++) push(64'h3333_3333_3333_3333, 64'h0, 1'b0);
    chk("t3_full", full, 1);
    chk("t3_count", count, 8);
    chk("t3_drop", drop_cnt, 2);
    chk("t3_head", out_data, {1'b0, 64'h3333_3333_3333_3333});

    // 4: simultaneous read/write while full, then drain across the wrap
    for (int i = 0; i < 3; i++) begin
      push(64'hA000 + 64'(i), 64'h0, 1'b1);
      chk("t4_count", count, 8);
      chk("t4_drop", drop_cnt, 2);
      chk("t4_head", out_data, {1'b0, 64'h3333_3333_3333_3333});
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t4_drain", out_data, (i < 5) ? {1'b0, 64'h3333_3333_3333_3333} : {1'b0, 64'hA000 + 64'(i - 5)});
      chk("t4_dvalid", out_valid, 1);
      tick();
    end
    out_ready = 1'b0;
    chk("t4_empty", out_valid, 0);
    chk("t4_cnt0", count, 0);
    tick();
    chk("t4_rdempty", count, 0);

    // 5: reset mid-operation with count=5 and a write in the reset cycle
    do_reset();
    for (int i = 0; i < 9; i++) push(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    out_ready = 1'b1;
    tick(); tick(); tick();
    out_ready = 1'b0;
    chk("t5_pre_count", count, 5);
    chk("t5_pre_carry", carry_cnt, 8);
    chk("t5_pre_drop", drop_cnt, 1);
    reset = 1'b1; sum_valid = 1'b1; sum_in = 64'h5555; cout_in = 1'b1;
    tick();
    reset = 1'b0; sum_valid = 1'b0;
    chk("t5_count", count, 0);
    chk("t5_valid", out_valid, 0);
    chk("t5_carry", carry_cnt, 0);
    chk("t5_drop", drop_cnt, 0);
    tick();
    chk("t5_nostore", count, 0);

    // 6: carry counter saturation
    do_reset();
    force dut.carry_cnt = 16'hFFFE;
    #1;
    release dut.carry_cnt;
    chk("t6_forced", carry_cnt, 16'hFFFE);
    push(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
    chk("t6_sat", carry_cnt, 16'hFFFF);
    push(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
    push(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
    chk("t6_hold", carry_cnt, 16'hFFFF);
    chk("t6_count", count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
